// File: rtl/uart_pkg.sv
// Shared state encoding, defaults and index helper for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned WORD_LENGTH_DEF    = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } tx_state_t;

    // Wraps at the requester count, not at the power of two of the index width.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active request at or after the pointer,
// wrapping modulo NUM_REQ. Reusable by any shared-resource controller.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [ID_W-1:0]    iPtr,
    output logic [NUM_REQ-1:0] oGrant,
    output logic [ID_W-1:0]    oIndex,
    output logic               oValid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        oGrant = '0;
        oIndex = '0;
        oValid = 1'b0;
        // First pass scans pointer..top, second pass wraps around to 0..pointer-1.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!oValid && iReq[j] && (ID_W'(j) >= iPtr)) begin
                oGrant[j] = 1'b1;
                oIndex    = ID_W'(j);
                oValid    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!oValid && iReq[j]) begin
                oGrant[j] = 1'b1;
                oIndex    = ID_W'(j);
                oValid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin grant,
// byte capture, start strobe, done tracking and a watchdog for a stalled UART.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned WORD_LENGTH    = WORD_LENGTH_DEF,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned ID_W           = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             iReq,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] iData,
    output logic [NUM_REQ-1:0]             oGrant,
    output logic [WORD_LENGTH-1:0]         oDataTX,
    output logic                           oTransmit,
    input  logic                           iTxDone,
    output logic                           oBusy,
    output logic [ID_W-1:0]                oOwner,
    output logic                           oTimeout,
    input  logic                           iClearTimeout
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    tx_state_t                r_state;
    logic [NUM_REQ-1:0]       r_grant;
    logic [WORD_LENGTH-1:0]   r_data;
    logic                     r_transmit;
    logic                     r_busy;
    logic [ID_W-1:0]          r_owner;
    logic                     r_timeout;
    logic [ID_W-1:0]          r_ptr;
    logic [WD_W-1:0]          r_wd;

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_index;
    logic                     w_valid;
    logic [WORD_LENGTH-1:0]   w_data;
    logic [ID_W-1:0]          w_next_ptr;
    logic                     w_wd_expired;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .iReq   (iReq),
        .iPtr   (r_ptr),
        .oGrant (w_grant),
        .oIndex (w_index),
        .oValid (w_valid)
    );

    always_comb begin
        w_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) w_data = iData[j*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    assign w_next_ptr   = ID_W'(wrap_inc(32'(r_owner), NUM_REQ));
    assign w_wd_expired = (r_wd == WD_LIMIT);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_data     <= '0;
            r_transmit <= 1'b0;
            r_busy     <= 1'b0;
            r_owner    <= '0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_wd       <= '0;
        end else begin
            r_grant    <= '0;
            r_transmit <= 1'b0;
            // A timeout firing in the same cycle overrides this clear below.
            if (iClearTimeout) r_timeout <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_valid && iTxDone) begin
                        r_grant <= w_grant;
                        r_data  <= w_data;
                        r_owner <= w_index;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: r_state <= START;
                START: begin
                    r_transmit <= 1'b1;
                    r_wd       <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!iTxDone) begin
                        r_wd    <= '0;
                        r_state <= WAIT_DONE;
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (iTxDone) begin
                        r_ptr   <= w_next_ptr;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oGrant    = r_grant;
    assign oDataTX   = r_data;
    assign oTransmit = r_transmit;
    assign oBusy     = r_busy;
    assign oOwner    = r_owner;
    assign oTimeout  = r_timeout;

endmodule
